fft2_init_ctrl: RTL and testbench
=================================

Name: fft2_init_ctrl

Overview:
- Parametrised successor of the single-channel fft2 init handshake.
- Accepts a 2D transform job (log2 width/height, direction, channel, pass mode) through a start/ready handshake and validates it.
- Latches the job and sequences a 1D line engine: row pass, then column pass, one line at a time.
- Sits between the host/config layer and the 1D FFT core; drives job completion and error status.

Parameters:
- FFT_SIZE, 16: max dimension per axis; power of two, 2..2^30.
- NUM_CH, 1: number of independent data channels selectable per job.
- LOG2_MAX, $clog2(FFT_SIZE): derived; max legal log2w/log2h.
- LW, $clog2(LOG2_MAX+1): derived; log2 field width, so log2=LOG2_MAX is representable.
- DW, LOG2_MAX+1: derived; dimension field width, so FFT_SIZE is representable.
- CW, (NUM_CH>1)?$clog2(NUM_CH):1: derived; channel field width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request, qualified by ready.
- ready  out  1  idle, accepting a job.
- log2w  in  LW  log2 of row length.
- log2h  in  LW  log2 of column length.
- inverse  in  1  1 = inverse transform.
- ch  in  CW  channel select.
- mode  in  2  00 rows+cols, 01 rows only, 10 cols only, 11 illegal.
- abort  in  1  cancel the running job.
- width  out  DW  latched 1<<log2w.
- height  out  DW  latched 1<<log2h.
- line_start  out  1  one-cycle line command.
- line_dir  out  1  0 row, 1 column.
- line_idx  out  DW-1  line number inside the current pass.
- line_log2  out  LW  log2 of points in the line.
- line_inv  out  1  latched inverse.
- line_ch  out  CW  latched ch.
- line_done  in  1  engine finished the current line.
- done  out  1  one-cycle job complete pulse.
- err  out  1  one-cycle reject/abort pulse.

Behaviour:
- All outputs are registered.
- Reset (rst=0): state IDLE; all outputs 0, including ready. ready rises on the first clk edge after rst deasserts.
- Reset asserted mid-job kills the job immediately. No done or err is issued.
- States: IDLE, ROW_ISSUE, ROW_WAIT, COL_ISSUE, COL_WAIT, FIN.
- IDLE: ready=1. An accept (start&&ready) with any illegal field pulses err next cycle; state stays IDLE, ready stays 1, and latched width/height are unchanged. Illegal fields are:
  - log2w==0 or log2w>LOG2_MAX
  - log2h==0 or log2h>LOG2_MAX
  - mode==11
  - ch>=NUM_CH
- IDLE, legal accept: latch all fields, set width/height, clear line_idx, drop ready next cycle. Mode 00/01 goes to ROW_ISSUE; mode 10 goes to COL_ISSUE.
- In mode 10, log2w is still validated and width is still latched.
- ROW_ISSUE: line_start=1 for exactly 1 cycle, with line_dir=0 and line_log2=log2w. Then ROW_WAIT.
- ROW_WAIT: on line_done, if line_idx==height-1:
  - clear line_idx
  - go to COL_ISSUE (mode 00) or FIN (mode 01)
- ROW_WAIT: on line_done otherwise, increment line_idx and go to ROW_ISSUE.
- COL_ISSUE/COL_WAIT: same pattern with line_dir=1 and line_log2=log2h. The last column is line_idx==width-1; after its line_done, go to FIN.
- FIN: done=1 for 1 cycle; next state IDLE, ready=1 the following cycle.
- line_done is ignored in every state except *_WAIT. A line_done in the same cycle as line_start is ignored.
- start while ready=0 is ignored. No queueing.
- abort in any non-IDLE state: next cycle IDLE, err=1 for 1 cycle, no done, line_start forced 0. abort in IDLE is ignored.
- abort and line_done in the same cycle: abort wins.
- Minimum job latency for mode 00, with line_done returned 1 cycle after each line_start: 2*(height+width) cycles, plus 1 for FIN.
- line_idx wraps only via explicit clear. It never exceeds max(width,height)-1.

Test Plan:
- Reset release: ready=0 while rst=0; ready=1 one edge after release; all other outputs 0.
- log2w=2, log2h=1, mode=00, inverse=1, ch=0, engine replies 1 cycle later. Expect:
  - width=4, height=2
  - 2 row starts: idx 0,1, dir=0, line_log2=2
  - 4 column starts: idx 0..3, dir=1, line_log2=1
  - line_inv=1 throughout
  - one done pulse, then ready=1
- FFT_SIZE=16, log2w=4, log2h=4, mode=01: width=16, 16 row starts idx 0..15, no column starts, done pulses once.
- Illegal accepts, each giving err pulse, no line_start, ready held 1, width/height unchanged:
  - log2w=5
  - log2h=0
  - mode=11
  - ch=1 with NUM_CH=1
- Abort during COL_WAIT at idx 2 of a 4x4 job, with line_done asserted in the same cycle: err pulse, no done, IDLE next cycle. A new 2x2 job then runs cleanly from idx 0.
- rst pulsed low during ROW_WAIT, plus start held high while busy: start is ignored while busy; reset clears state to IDLE with outputs 0; no done or err is produced.

Source files
------------

// File: rtl/fft2_init_ctrl.sv
// 2D FFT job controller: validates and latches a job, then drives the 1D line
// engine through a row pass and/or a column pass, one line at a time.
module fft2_init_ctrl #(
    parameter int  FFT_SIZE = 16,
    parameter int  NUM_CH   = 1,
    localparam int LOG2_MAX = $clog2(FFT_SIZE),
    localparam int LW       = $clog2(LOG2_MAX + 1),
    localparam int DW       = LOG2_MAX + 1,
    localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    input  logic [LW-1:0] log2w,
    input  logic [LW-1:0] log2h,
    input  logic          inverse,
    input  logic [CW-1:0] ch,
    input  logic [1:0]    mode,
    input  logic          abort,
    output logic [DW-1:0] width,
    output logic [DW-1:0] height,
    output logic          line_start,
    output logic          line_dir,
    output logic [DW-2:0] line_idx,
    output logic [LW-1:0] line_log2,
    output logic          line_inv,
    output logic [CW-1:0] line_ch,
    input  logic          line_done,
    output logic          done,
    output logic          err
);

    localparam logic [LW-1:0] LOG2_MAX_L = LW'(LOG2_MAX);
    localparam logic [CW:0]   NUM_CH_L   = (CW + 1)'(NUM_CH);

    localparam logic [1:0] MODE_ROWS_COLS = 2'b00;
    localparam logic [1:0] MODE_COLS_ONLY = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ROW_ISSUE,
        ROW_WAIT,
        COL_ISSUE,
        COL_WAIT,
        FIN
    } state_t;

    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    logic [DW-1:0] width_q, width_d;
    logic [DW-1:0] height_q, height_d;
    logic          line_start_q, line_start_d;
    logic          line_dir_q, line_dir_d;
    logic [DW-2:0] line_idx_q, line_idx_d;
    logic [LW-1:0] line_log2_q, line_log2_d;
    logic          line_inv_q, line_inv_d;
    logic [CW-1:0] line_ch_q, line_ch_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [LW-1:0] log2w_q, log2w_d;
    logic [LW-1:0] log2h_q, log2h_d;
    logic [1:0]    mode_q, mode_d;

    logic job_ok;
    logic row_last;
    logic col_last;

    always_comb begin
        job_ok = (log2w != '0) && (log2w <= LOG2_MAX_L) &&
                 (log2h != '0) && (log2h <= LOG2_MAX_L) &&
                 (mode != MODE_ILLEGAL) && ({1'b0, ch} < NUM_CH_L);
        row_last = ({1'b0, line_idx_q} == (height_q - DW'(1)));
        col_last = ({1'b0, line_idx_q} == (width_q - DW'(1)));
    end

    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        width_d      = width_q;
        height_d     = height_q;
        line_start_d = 1'b0;
        line_dir_d   = line_dir_q;
        line_idx_d   = line_idx_q;
        line_log2_d  = line_log2_q;
        line_inv_d   = line_inv_q;
        line_ch_d    = line_ch_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        log2w_d      = log2w_q;
        log2h_d      = log2h_q;
        mode_d       = mode_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (start && ready_q) begin
                    if (!job_ok) begin
                        err_d = 1'b1;
                    end else begin
                        ready_d    = 1'b0;
                        width_d    = DW'(1) << log2w;
                        height_d   = DW'(1) << log2h;
                        log2w_d    = log2w;
                        log2h_d    = log2h;
                        mode_d     = mode;
                        line_inv_d = inverse;
                        line_ch_d  = ch;
                        line_idx_d = '0;
                        line_start_d = 1'b1;
                        if (mode == MODE_COLS_ONLY) begin
                            state_d     = COL_ISSUE;
                            line_dir_d  = 1'b1;
                            line_log2_d = log2h;
                        end else begin
                            state_d     = ROW_ISSUE;
                            line_dir_d  = 1'b0;
                            line_log2_d = log2w;
                        end
                    end
                end
            end
            // The issue cycle never looks at line_done, so a reply that
            // coincides with line_start is dropped.
            ROW_ISSUE: state_d = ROW_WAIT;
            ROW_WAIT: begin
                if (line_done) begin
                    if (row_last) begin
                        line_idx_d = '0;
                        if (mode_q == MODE_ROWS_COLS) begin
                            state_d      = COL_ISSUE;
                            line_start_d = 1'b1;
                            line_dir_d   = 1'b1;
                            line_log2_d  = log2h_q;
                        end else begin
                            state_d = FIN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        line_idx_d   = line_idx_q + 1'b1;
                        state_d      = ROW_ISSUE;
                        line_start_d = 1'b1;
                        line_dir_d   = 1'b0;
                        line_log2_d  = log2w_q;
                    end
                end
            end
            COL_ISSUE: state_d = COL_WAIT;
            COL_WAIT: begin
                if (line_done) begin
                    if (col_last) begin
                        line_idx_d = '0;
                        state_d    = FIN;
                        done_d     = 1'b1;
                    end else begin
                        line_idx_d   = line_idx_q + 1'b1;
                        state_d      = COL_ISSUE;
                        line_start_d = 1'b1;
                        line_dir_d   = 1'b1;
                        line_log2_d  = log2h_q;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase

        // Abort overrides whatever the pass logic decided this cycle.
        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            ready_d      = 1'b1;
            err_d        = 1'b1;
            done_d       = 1'b0;
            line_start_d = 1'b0;
            line_idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            width_q      <= '0;
            height_q     <= '0;
            line_start_q <= 1'b0;
            line_dir_q   <= 1'b0;
            line_idx_q   <= '0;
            line_log2_q  <= '0;
            line_inv_q   <= 1'b0;
            line_ch_q    <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            log2w_q      <= '0;
            log2h_q      <= '0;
            mode_q       <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            width_q      <= width_d;
            height_q     <= height_d;
            line_start_q <= line_start_d;
            line_dir_q   <= line_dir_d;
            line_idx_q   <= line_idx_d;
            line_log2_q  <= line_log2_d;
            line_inv_q   <= line_inv_d;
            line_ch_q    <= line_ch_d;
            done_q       <= done_d;
            err_q        <= err_d;
            log2w_q      <= log2w_d;
            log2h_q      <= log2h_d;
            mode_q       <= mode_d;
        end
    end

    assign ready      = ready_q;
    assign width      = width_q;
    assign height     = height_q;
    assign line_start = line_start_q;
    assign line_dir   = line_dir_q;
    assign line_idx   = line_idx_q;
    assign line_log2  = line_log2_q;
    assign line_inv   = line_inv_q;
    assign line_ch    = line_ch_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fft2_init_ctrl.sv
// Bench for fft2_init_ctrl: directed and random jobs checked against a line
// list built from the job fields, with an engine model answering line_start.
module tb_fft2_init_ctrl;

    localparam int FFT_SIZE = 16;
    localparam int NUM_CH   = 1;
    localparam int LOG2_MAX = $clog2(FFT_SIZE);
    localparam int LW       = $clog2(LOG2_MAX + 1);
    localparam int DW       = LOG2_MAX + 1;
    localparam int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          ready;
    logic [LW-1:0] log2w;
    logic [LW-1:0] log2h;
    logic          inverse;
    logic [CW-1:0] ch;
    logic [1:0]    mode;
    logic          abort;
    logic [DW-1:0] width;
    logic [DW-1:0] height;
    logic          line_start;
    logic          line_dir;
    logic [DW-2:0] line_idx;
    logic [LW-1:0] line_log2;
    logic          line_inv;
    logic [CW-1:0] line_ch;
    logic          line_done;
    logic          done;
    logic          err;

    int total;
    int bad;
    int cur_w;
    int cur_h;

    fft2_init_ctrl #(.FFT_SIZE(FFT_SIZE), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .log2w(log2w), .log2h(log2h), .inverse(inverse), .ch(ch),
        .mode(mode), .abort(abort), .width(width), .height(height),
        .line_start(line_start), .line_dir(line_dir), .line_idx(line_idx),
        .line_log2(line_log2), .line_inv(line_inv), .line_ch(line_ch),
        .line_done(line_done), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int key(input int d, input int i, input int l);
        return d * 10000 + i * 100 + l;
    endfunction

    // Submit one job, act as the line engine, and compare the whole run
    // against the line list implied by the job fields.
    task automatic run_job(input int lw, input int lh, input int inv, input int chv,
                           input int md, input int max_d, input bit spur_en,
                           input int abort_key);
        int  exp_q[$];
        int  got_q[$];
        bit  legal;
        bit  fin;
        bit  armed;
        int  w, h, cnt, dones, errs, abort_pos, k;
        logic ls_at_end, rdy_at_end;

        legal = (lw >= 1) && (lw <= LOG2_MAX) && (lh >= 1) && (lh <= LOG2_MAX) &&
                (md != 3) && (chv < NUM_CH);
        w = 1 << lw;
        h = 1 << lh;
        abort_pos = -1;
        if (legal) begin
            if (md != 2) for (int i = 0; i < h; i++) exp_q.push_back(key(0, i, lw));
            if (md != 1) for (int i = 0; i < w; i++) exp_q.push_back(key(1, i, lh));
            for (int i = 0; i < exp_q.size(); i++)
                if (exp_q[i] == abort_key && abort_pos < 0) abort_pos = i;
        end

        log2w   = LW'(lw);
        log2h   = LH_CAST(lh);
        inverse = inv[0];
        ch      = CW'(chv);
        mode    = 2'(md);
        start   = 1'b1;
        fin = 0; armed = 0; cnt = 0; dones = 0; errs = 0;
        ls_at_end = 1'b0; rdy_at_end = 1'b0;

        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            start     = 1'b0;
            abort     = 1'b0;
            line_done = 1'b0;
            if (line_start === 1'b1) begin
                k = key(int'(line_dir), int'(line_idx), int'(line_log2));
                got_q.push_back(k);
                chk("line_inv", 32'(line_inv), 32'(inv[0]));
                chk("line_ch", 32'(line_ch), 32'(chv));
            end
            if (done === 1'b1) dones++;
            if (err === 1'b1) errs++;
            if (done === 1'b1 || err === 1'b1) begin
                fin = 1;
                ls_at_end  = line_start;
                rdy_at_end = ready;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        line_done = 1'b1;
                        if (armed) abort = 1'b1;
                    end
                end
                if (line_start === 1'b1) begin
                    if (spur_en && $urandom_range(0, 1) == 1) line_done = 1'b1;
                    cnt = int'($urandom_range(1, max_d));
                    if (k == abort_key) begin
                        armed = 1;
                        cnt   = 1;
                    end
                end
            end
        end
        abort     = 1'b0;
        line_done = 1'b0;
        if (!fin) chk("timeout", 32'd0, 32'd1);

        if (!legal) begin
            chk("rej_err", 32'(errs), 32'd1);
            chk("rej_done", 32'(dones), 32'd0);
            chk("rej_lines", 32'(got_q.size()), 32'd0);
            chk("rej_ready", 32'(rdy_at_end), 32'd1);
            chk("rej_width", 32'(width), 32'(cur_w));
            chk("rej_height", 32'(height), 32'(cur_h));
        end else begin
            cur_w = w;
            cur_h = h;
            chk("width", 32'(width), 32'(w));
            chk("height", 32'(height), 32'(h));
            if (abort_pos >= 0) begin
                chk("abort_err", 32'(errs), 32'd1);
                chk("abort_done", 32'(dones), 32'd0);
                chk("abort_lines", 32'(got_q.size()), 32'(abort_pos + 1));
                chk("abort_ls", 32'(ls_at_end), 32'd0);
                chk("abort_ready", 32'(rdy_at_end), 32'd1);
            end else begin
                chk("job_done", 32'(dones), 32'd1);
                chk("job_err", 32'(errs), 32'd0);
                chk("job_lines", 32'(got_q.size()), 32'(exp_q.size()));
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                chk($sformatf("line%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end

        @(negedge clk);
        chk("after_ready", 32'(ready), 32'd1);
        chk("after_done", 32'(done), 32'd0);
        chk("after_err", 32'(err), 32'd0);
        $display("job lw=%0d lh=%0d md=%0d ch=%0d inv=%0d lines=%0d done=%0d err=%0d",
                 lw, lh, md, chv, inv, got_q.size(), dones, errs);
    endtask

    function automatic logic [LW-1:0] LH_CAST(input int v);
        return LW'(v);
    endfunction

    initial begin
        int got_q[$];
        int seen, pend, dn, er;
        int lw, lh, md, chv;
        total = 0; bad = 0; cur_w = 0; cur_h = 0;
        rst = 1'b0; start = 1'b0; log2w = '0; log2h = '0; inverse = 1'b0;
        ch = '0; mode = 2'b00; abort = 1'b0; line_done = 1'b0;

        // Reset behaviour
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_width", 32'(width), 32'd0);
        chk("rst_height", 32'(height), 32'd0);
        chk("rst_ls", 32'(line_start), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_idx", 32'(line_idx), 32'd0);
        chk("rst_inv", 32'(line_inv), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_ready0", 32'(ready), 32'd0);
        @(negedge clk);
        chk("rel_ready1", 32'(ready), 32'd1);
        chk("rel_done", 32'(done), 32'd0);
        chk("rel_err", 32'(err), 32'd0);

        // Directed jobs
        run_job(2, 1, 1, 0, 0, 1, 1'b0, -1);
        run_job(4, 4, 0, 0, 1, 1, 1'b0, -1);
        run_job(5, 1, 0, 0, 0, 1, 1'b0, -1);
        run_job(2, 0, 0, 0, 0, 1, 1'b0, -1);
        run_job(2, 2, 0, 0, 3, 1, 1'b0, -1);
        run_job(2, 2, 0, 1, 0, 1, 1'b0, -1);
        run_job(3, 2, 1, 0, 2, 2, 1'b1, -1);
        run_job(2, 2, 0, 0, 0, 1, 1'b0, key(1, 2, 2));
        run_job(1, 1, 0, 0, 0, 1, 1'b0, -1);

        // Reset during ROW_WAIT with start held high throughout
        log2w = 3'd2; log2h = 3'd2; mode = 2'b00; inverse = 1'b1; ch = '0;
        start = 1'b1;
        seen = 0; pend = 0;
        for (int c = 0; c < 200 && seen < 3; c++) begin
            @(negedge clk);
            line_done = 1'b0;
            if (pend != 0) begin
                line_done = 1'b1;
                pend = 0;
            end
            if (line_start === 1'b1) begin
                got_q.push_back(key(int'(line_dir), int'(line_idx), int'(line_log2)));
                seen++;
                pend = 1;
            end
        end
        chk("busy_starts", 32'(seen), 32'd3);
        for (int i = 0; i < got_q.size(); i++)
            chk($sformatf("busy_line%0d", i), 32'(got_q[i]), 32'(key(0, i, 2)));
        @(negedge clk);
        line_done = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_ready", 32'(ready), 32'd0);
        chk("mid_ls", 32'(line_start), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        chk("mid_width", 32'(width), 32'd0);
        chk("mid_height", 32'(height), 32'd0);
        chk("mid_idx", 32'(line_idx), 32'd0);
        chk("mid_inv", 32'(line_inv), 32'd0);
        start = 1'b0;
        cur_w = 0; cur_h = 0;
        @(negedge clk);
        chk("mid_ready_held", 32'(ready), 32'd0);
        rst = 1'b1;
        dn = 0; er = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
            if (err === 1'b1) er++;
        end
        chk("mid_no_done", 32'(dn), 32'd0);
        chk("mid_no_err", 32'(er), 32'd0);
        chk("mid_ready_back", 32'(ready), 32'd1);
        $display("reset mid-job: starts=%0d done=%0d err=%0d", seen, dn, er);

        // Random jobs, mostly legal
        for (int j = 0; j < 25; j++) begin
            if ($urandom_range(0, 3) != 0) begin
                lw  = int'($urandom_range(1, LOG2_MAX));
                lh  = int'($urandom_range(1, LOG2_MAX));
                md  = int'($urandom_range(0, 2));
                chv = int'($urandom_range(0, NUM_CH - 1));
            end else begin
                lw  = int'($urandom_range(0, (1 << LW) - 1));
                lh  = int'($urandom_range(0, (1 << LW) - 1));
                md  = int'($urandom_range(0, 3));
                chv = int'($urandom_range(0, (1 << CW) - 1));
            end
            run_job(lw, lh, int'($urandom_range(0, 1)), chv, md,
                    int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
